// File: rtl/spi_slave_rx_mode2.sv
// SPI mode-2 (CPOL=1, CPHA=0) receive-only slave.
// All SPI inputs are resynchronised into In_clk. MOSI is sampled on falling SCLK,
// MSB first, and each completed byte is presented with a one-cycle valid strobe.
module spi_slave_rx_mode2 #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       In_clk,
  input  logic       In_rst_n,
  input  logic       In_spi_cs_n,
  input  logic       In_spi_sclk,
  input  logic       In_spi_mosi,
  output logic [7:0] Out_rx_data,
  output logic       Out_rx_valid,
  output logic       Out_rx_busy,
  output logic       Out_rx_err
);

  localparam int unsigned SW     = SYNC_STAGES;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned DATA_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_e;

  // Synchroniser chains and edge-detect history
  logic [SW-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic          cs_hist_q, sclk_hist_q;

  // Receiver state
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  // A frame is only entered after CS has genuinely been seen high since reset
  logic                post_rst_q, post_rst_d;
  logic                armed_q, armed_d;

  logic cs_s, sclk_s, mosi_s;
  logic cs_fall, cs_rise, sclk_fall;

  assign cs_s      = cs_sync_q[SW-1];
  assign sclk_s    = sclk_sync_q[SW-1];
  assign mosi_s    = mosi_sync_q[SW-1];
  assign cs_fall   = cs_hist_q & ~cs_s;
  assign cs_rise   = ~cs_hist_q & cs_s;
  assign sclk_fall = sclk_hist_q & ~sclk_s;

  // Input synchronisers, identical depth on all three lines to keep alignment
  always_ff @(posedge In_clk) begin
    if (!In_rst_n) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '1;
      mosi_sync_q <= '0;
      cs_hist_q   <= 1'b1;
      sclk_hist_q <= 1'b1;
    end else begin
      cs_sync_q   <= {cs_sync_q[SW-2:0], In_spi_cs_n};
      sclk_sync_q <= {sclk_sync_q[SW-2:0], In_spi_sclk};
      mosi_sync_q <= {mosi_sync_q[SW-2:0], In_spi_mosi};
      cs_hist_q   <= cs_s;
      sclk_hist_q <= sclk_s;
    end
  end

  // State and output registers
  always_ff @(posedge In_clk) begin
    if (!In_rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      post_rst_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      post_rst_q <= post_rst_d;
      armed_q    <= armed_d;
    end
  end

  // Next-state: frame tracking, bit shifting, strobes; CS rise beats a coincident SCLK fall
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    busy_d     = ~cs_s;
    post_rst_d = 1'b1;
    // First stage holds a real CS sample only from the second post-reset cycle on
    armed_d    = armed_q | (post_rst_q & cs_sync_q[0]);

    case (state_q)
      ST_IDLE: begin
        if (cs_fall && armed_q) begin
          state_d   = ST_RECV;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      ST_RECV: begin
        if (cs_rise) begin
          state_d   = ST_IDLE;
          err_d     = (bit_cnt_q != CNT_W'(0));
          bit_cnt_d = '0;
          shift_d   = '0;
        end else if (sclk_fall) begin
          shift_d   = {shift_q[DATA_W-2:0], mosi_s};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(7)) begin
            data_d  = {shift_q[DATA_W-2:0], mosi_s};
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign Out_rx_data  = data_q;
  assign Out_rx_valid = valid_q;
  assign Out_rx_err   = err_q;
  assign Out_rx_busy  = busy_q;

endmodule

// File: tb/tb_spi_slave_rx_mode2.sv
// Directed bench for spi_slave_rx_mode2: drives mode-2 SPI frames and checks strobes/data.
module tb_spi_slave_rx_mode2;

  logic       clk;
  logic       rst_n;
  logic       cs_n;
  logic       sclk;
  logic       mosi;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       rx_err;

  int checks = 0;
  int errors = 0;

  // Monitor state (written only by the monitor process)
  int         valid_cnt = 0;
  int         err_cnt   = 0;
  int         both_cnt  = 0;
  int         busy_bad  = 0;
  logic [7:0] cap [16];
  logic       frame_chk = 1'b0;

  spi_slave_rx_mode2 #(.SYNC_STAGES(2)) dut (
    .In_clk      (clk),
    .In_rst_n    (rst_n),
    .In_spi_cs_n (cs_n),
    .In_spi_sclk (sclk),
    .In_spi_mosi (mosi),
    .Out_rx_data (rx_data),
    .Out_rx_valid(rx_valid),
    .Out_rx_busy (rx_busy),
    .Out_rx_err  (rx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record strobes and captured bytes away from the active edge
  always @(negedge clk) begin
    if (rx_valid) begin
      cap[valid_cnt % 16] = rx_data;
      valid_cnt = valid_cnt + 1;
    end
    if (rx_err) err_cnt = err_cnt + 1;
    if (rx_valid && rx_err) both_cnt = both_cnt + 1;
    if (frame_chk && !rx_busy) busy_bad = busy_bad + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Send the top n bits of b, MSB first; MOSI changes on the rising (trailing) edge
  task automatic send_bits(input logic [7:0] b, input int n, input int half);
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      cyc(half);
      sclk = 1'b0;
      cyc(half);
      sclk = 1'b1;
    end
  endtask

  task automatic frame(input logic [7:0] b, input int half);
    cs_n = 1'b0;
    cyc(10);
    send_bits(b, 8, half);
    cyc(10);
    cs_n = 1'b1;
    cyc(10);
  endtask

  int base_v, base_e;

  initial begin
    rst_n = 1'b0;
    cs_n  = 1'b1;
    sclk  = 1'b1;
    mosi  = 1'b0;
    cyc(4);
    chk("reset_data",  32'(rx_data),  32'h00);
    chk("reset_valid", 32'(rx_valid), 32'h0);
    chk("reset_err",   32'(rx_err),   32'h0);
    chk("reset_busy",  32'(rx_busy),  32'h0);
    rst_n = 1'b1;
    cyc(6);

    // Single byte 0xA5
    base_v = valid_cnt; base_e = err_cnt;
    cs_n = 1'b0;
    cyc(10);
    chk("a5_busy_in_frame", 32'(rx_busy), 32'h1);
    send_bits(8'hA5, 8, 8);
    cyc(10);
    cs_n = 1'b1;
    cyc(10);
    chk("a5_valid_count", 32'(valid_cnt - base_v), 32'd1);
    chk("a5_cap",         32'(cap[base_v % 16]),   32'hA5);
    chk("a5_data",        32'(rx_data),            32'hA5);
    chk("a5_err_count",   32'(err_cnt - base_e),   32'd0);
    chk("a5_busy_after",  32'(rx_busy),            32'h0);

    // Back-to-back 0x3C, 0xC3 in one frame
    base_v = valid_cnt; base_e = err_cnt;
    cs_n = 1'b0;
    cyc(10);
    frame_chk = 1'b1;
    send_bits(8'h3C, 8, 8);
    send_bits(8'hC3, 8, 8);
    cyc(10);
    frame_chk = 1'b0;
    cs_n = 1'b1;
    cyc(10);
    chk("b2b_valid_count", 32'(valid_cnt - base_v),     32'd2);
    chk("b2b_first",       32'(cap[base_v % 16]),       32'h3C);
    chk("b2b_second",      32'(cap[(base_v + 1) % 16]), 32'hC3);
    chk("b2b_busy_frame",  32'(busy_bad),               32'd0);
    chk("b2b_err_count",   32'(err_cnt - base_e),       32'd0);

    // Abort: 0x5A then a 5-bit frame
    frame(8'h5A, 8);
    chk("abort_pre_data", 32'(rx_data), 32'h5A);
    base_v = valid_cnt; base_e = err_cnt;
    cs_n = 1'b0;
    cyc(10);
    send_bits(8'hF8, 5, 8);
    cyc(10);
    cs_n = 1'b1;
    cyc(10);
    chk("abort_err_count",   32'(err_cnt - base_e),   32'd1);
    chk("abort_valid_count", 32'(valid_cnt - base_v), 32'd0);
    chk("abort_data",        32'(rx_data),            32'h5A);

    // Idle noise with CS high
    base_v = valid_cnt; base_e = err_cnt;
    for (int i = 0; i < 16; i++) begin
      mosi = 1'($urandom_range(0, 1));
      cyc(4);
      sclk = ~sclk;
    end
    cyc(10);
    chk("idle_valid_count", 32'(valid_cnt - base_v), 32'd0);
    chk("idle_err_count",   32'(err_cnt - base_e),   32'd0);
    chk("idle_data",        32'(rx_data),            32'h5A);
    chk("idle_busy",        32'(rx_busy),            32'h0);

    // Reset mid-byte, then a CS-low tail that must be ignored, then a fresh 0xFF frame
    cs_n = 1'b0;
    cyc(10);
    send_bits(8'hE0, 3, 8);
    rst_n = 1'b0;
    cyc(3);
    chk("rst_mid_data", 32'(rx_data), 32'h00);
    rst_n = 1'b1;
    base_v = valid_cnt; base_e = err_cnt;
    cyc(10);
    send_bits(8'h11, 8, 8);
    cyc(10);
    cs_n = 1'b1;
    cyc(10);
    chk("rst_stale_valid", 32'(valid_cnt - base_v), 32'd0);
    chk("rst_stale_err",   32'(err_cnt - base_e),   32'd0);
    chk("rst_stale_data",  32'(rx_data),            32'h00);
    frame(8'hFF, 8);
    chk("rst_new_valid", 32'(valid_cnt - base_v), 32'd1);
    chk("rst_new_data",  32'(rx_data),            32'hFF);

    // Ratio limit: SCLK period of exactly 8 In_clk cycles
    base_v = valid_cnt; base_e = err_cnt;
    frame(8'h81, 4);
    chk("ratio_valid_count", 32'(valid_cnt - base_v), 32'd1);
    chk("ratio_data",        32'(rx_data),            32'h81);
    chk("ratio_err_count",   32'(err_cnt - base_e),   32'd0);

    chk("valid_err_overlap", 32'(both_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
